// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: two-entry (main + skid) elastic pipeline register with
// valid/ready handshaking, N-way stall merge, control-killing flush and
// saturating stall/bubble performance counters.
module pipe_stage_elastic #(
   parameter int DATA_W  = 160,
   parameter int CTRL_W  = 16,
   parameter int N_STALL = 2,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_STALL-1:0] i_stall,
   input  logic               i_flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [CTRL_W-1:0]  in_ctrl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic [CNT_W-1:0]   o_stall_cnt,
   output logic [CNT_W-1:0]   o_bubble_cnt
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

   logic stall;
   logic main_valid;
   logic can_accept;
   logic in_fire;
   logic out_fire;

   // Handshake qualifiers; rst only masks the visible in_ready, the flops are
   // held in reset anyway so the internal accept term does not need it.
   always_comb begin
      stall      = |i_stall;
      main_valid = (state_q != ST_EMPTY);
      can_accept = (state_q != ST_TWO) && !stall;
      in_ready   = can_accept && !rst;
      out_valid  = main_valid && !stall;
      in_fire    = in_valid && can_accept;
      out_fire   = out_valid && out_ready;
      out_data   = main_data_q;
      out_ctrl   = main_ctrl_q;
      o_stall_cnt  = stall_cnt_q;
      o_bubble_cnt = bubble_cnt_q;
   end

   // Buffer occupancy and entry movement; flush overrides every fire.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (i_flush) begin
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d     = ST_ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (in_fire) begin
                  state_d     = ST_TWO;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_d     = ST_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Saturating performance counters; unaffected by flush.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall && main_valid && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (out_ready && !main_valid && !stall && (bubble_cnt_q != {CNT_W{1'b1}}))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic: table-driven streaming vectors, directed
// multi-cycle corner cases and randomized traffic against a queue model.
module tb_pipe_stage_elastic;

   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    i_stall;
   logic          i_flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_ready;

   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [15:0]   stall_cnt, bub_cnt;

   logic          s_in_ready, s_out_valid;
   logic [DW-1:0] s_out_data;
   logic [CW-1:0] s_out_ctrl;
   logic [3:0]    s_stall_cnt, s_bub_cnt;

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .N_STALL(2), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .o_stall_cnt(stall_cnt), .o_bubble_cnt(bub_cnt));

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .N_STALL(2), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
      .o_stall_cnt(s_stall_cnt), .o_bubble_cnt(s_bub_cnt));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit verbose = 1'b1;

   // Behavioural model: FIFO of capacity two plus visible head register.
   typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; } beat_t;
   beat_t         mq[$];
   logic [DW-1:0] head_data;
   logic [CW-1:0] head_ctrl;
   int            m_stall, m_bub, m_stall4, m_bub4;
   bit            last_in_fire;
   logic [DW-1:0] delivered[$];

   typedef struct {
      logic [1:0]    stall;
      logic          flush, in_valid, out_ready;
      logic [DW-1:0] data;
      logic          exp_in_ready, exp_out_valid;
      logic [DW-1:0] exp_out_data;
      logic [15:0]   exp_bubble;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      head_data = '0;
      head_ctrl = '0;
      m_stall = 0; m_bub = 0; m_stall4 = 0; m_bub4 = 0;
   endtask

   // One clock cycle: compare against the model mid-cycle, advance the model.
   task automatic step();
      bit st, e_ir, e_ov, in_f, out_f;
      logic [DW-1:0] e_od;
      logic [CW-1:0] e_oc;
      @(negedge clk);
      st   = (i_stall != 2'b00);
      e_ir = (mq.size() < 2) && !st;
      e_ov = (mq.size() > 0) && !st;
      e_od = (mq.size() > 0) ? mq[0].d : head_data;
      e_oc = (mq.size() > 0) ? mq[0].c : head_ctrl;
      chk("in_ready", 64'(in_ready), 64'(e_ir));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("out_data", 64'(out_data), 64'(e_od));
      chk("out_ctrl", 64'(out_ctrl), 64'(e_oc));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("bubble_cnt", 64'(bub_cnt), 64'(m_bub));
      chk("sat_in_ready", 64'(s_in_ready), 64'(e_ir));
      chk("sat_out_valid", 64'(s_out_valid), 64'(e_ov));
      chk("sat_out_data", 64'(s_out_data), 64'(e_od));
      chk("sat_out_ctrl", 64'(s_out_ctrl), 64'(e_oc));
      chk("sat_stall_cnt", 64'(s_stall_cnt), 64'(m_stall4));
      chk("sat_bubble_cnt", 64'(s_bub_cnt), 64'(m_bub4));
      if (out_valid && out_ready) begin
         delivered.push_back(out_data);
         if (verbose) $display("[TB] t=%0t beat out data=%0h ctrl=%0h", $time, out_data, out_ctrl);
      end
      in_f  = in_valid && e_ir;
      out_f = e_ov && out_ready;
      last_in_fire = in_f;
      if (st && mq.size() > 0) begin
         if (m_stall < 65535) m_stall++;
         if (m_stall4 < 15) m_stall4++;
      end
      if (out_ready && mq.size() == 0 && !st) begin
         if (m_bub < 65535) m_bub++;
         if (m_bub4 < 15) m_bub4++;
      end
      if (i_flush) begin
         mq.delete();
         head_ctrl = '0;
      end else begin
         if (out_f) void'(mq.pop_front());
         if (in_f) mq.push_back('{d: in_data, c: in_ctrl});
         if (mq.size() > 0) begin
            head_data = mq[0].d;
            head_ctrl = mq[0].c;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_stall = 2'b00; i_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_ctrl = '0;
   endtask

   function automatic vec_t mk(input logic iv, input logic ordy, input logic [DW-1:0] d,
                               input logic eir, input logic eov, input logic [DW-1:0] eod,
                               input logic [15:0] ebub);
      vec_t v;
      v.stall = 2'b00; v.flush = 1'b0; v.in_valid = iv; v.out_ready = ordy; v.data = d;
      v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_out_data = eod; v.exp_bubble = ebub;
      return v;
   endfunction

   initial begin
      logic [DW-1:0] beats[4];
      int idx;
      logic [15:0] s0;

      // Streaming table: beats 1..8, each visible one cycle after acceptance.
      vecs.push_back(mk(1'b1, 1'b0, 32'd1, 1'b1, 1'b0, 32'd0, 16'd0));
      for (int k = 1; k < 8; k++)
         vecs.push_back(mk(1'b1, 1'b1, 32'(k + 1), 1'b1, 1'b1, 32'(k), 16'd0));
      vecs.push_back(mk(1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 32'd8, 16'd0));
      vecs.push_back(mk(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 32'd8, 16'd0));
      vecs.push_back(mk(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 32'd8, 16'd1));

      // Reset state while rst is held.
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_bubble_cnt", 64'(bub_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Table-driven streaming.
      foreach (vecs[i]) begin
         i_stall = vecs[i].stall; i_flush = vecs[i].flush;
         in_valid = vecs[i].in_valid; out_ready = vecs[i].out_ready;
         in_data = vecs[i].data; in_ctrl = vecs[i].data[CW-1:0] ^ 8'h5A;
         #1;
         chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
         chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
         chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_out_data));
         chk($sformatf("vec%0d_bubble", i), 64'(bub_cnt), 64'(vecs[i].exp_bubble));
         step();
      end

      // Backpressure: two cycles of out_ready low after beat 1 is presented.
      idle_inputs();
      delivered.delete();
      beats[0] = 32'd1; beats[1] = 32'd2; beats[2] = 32'd3; beats[3] = 32'd4;
      idx = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         in_valid  = (idx < 4);
         in_data   = (idx < 4) ? beats[idx] : '0;
         in_ctrl   = 8'hB0 + 8'(idx);
         out_ready = !(cyc == 1 || cyc == 2);
         #1;
         if (cyc == 1) chk("bp_ready_absorbs", 64'(in_ready), 64'd1);
         if (cyc == 2) chk("bp_in_ready_two", 64'(in_ready), 64'd0);
         step();
         if (last_in_fire) idx++;
      end
      chk("bp_count", 64'(delivered.size()), 64'd4);
      for (int k = 0; k < 4; k++)
         if (k < delivered.size()) chk($sformatf("bp_order%0d", k), 64'(delivered[k]), 64'(k + 1));

      // Flush while TWO (offered beat in the same cycle), then flush in ONE with in_fire.
      idle_inputs();
      delivered.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h31; in_ctrl = 8'hC1; step();
      in_data = 32'h32; in_ctrl = 8'hC2; step();
      i_flush = 1'b1; in_data = 32'h77; in_ctrl = 8'hE7; step();
      i_flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush2_out_valid", 64'(out_valid), 64'd0);
      chk("flush2_out_ctrl", 64'(out_ctrl), 64'd0);
      in_valid = 1'b1; in_data = 32'h41; in_ctrl = 8'hC4; step();
      i_flush = 1'b1; in_data = 32'h88; in_ctrl = 8'hE8; step();
      i_flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush1_out_valid", 64'(out_valid), 64'd0);
      chk("flush1_out_ctrl", 64'(out_ctrl), 64'd0);
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h51; in_ctrl = 8'hC5; step();
      in_valid = 1'b0; step(); step();
      chk("flush_delivered_count", 64'(delivered.size()), 64'd1);
      if (delivered.size() > 0) chk("flush_delivered0", 64'(delivered[0]), 64'h51);

      // Stall for 3 cycles with beat 0xA held.
      idle_inputs();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h0A; step();
      in_valid = 1'b0; out_ready = 1'b1;
      s0 = stall_cnt;
      i_stall = 2'b10;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_out_valid", 64'(out_valid), 64'd0);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_data", 64'(out_data), 64'hA);
         step();
      end
      chk("stall_cnt_plus3", 64'(stall_cnt - s0), 64'd3);
      i_stall = 2'b00;
      delivered.delete();
      step();
      chk("stall_release_deliver", 64'(delivered.size()), 64'd1);
      if (delivered.size() > 0) chk("stall_release_data", 64'(delivered[0]), 64'hA);

      // Saturation of the 4-bit counter over 20 stalled cycles.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h66; in_ctrl = 8'h66; step();
      in_valid = 1'b0;
      s0 = stall_cnt;
      i_stall = 2'b01;
      repeat (20) step();
      chk("sat_stall_15", 64'(s_stall_cnt), 64'd15);
      chk("wide_stall_plus20", 64'(stall_cnt - s0), 64'd20);
      i_stall = 2'b00; out_ready = 1'b1; step(); step();

      // Randomized traffic.
      verbose = 1'b0;
      for (int k = 0; k < 400; k++) begin
         i_stall   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         i_flush   = ($urandom_range(0, 19) == 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_ctrl   = 8'($urandom);
         step();
      end
      verbose = 1'b1;

      // Asynchronous reset pulse between edges, mid-stream.
      idle_inputs();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h91; in_ctrl = 8'h91; step();
      in_data = 32'h92; in_ctrl = 8'h92; step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_data", 64'(out_data), 64'd0);
      chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("arst_bubble_cnt", 64'(bub_cnt), 64'd0);
      chk("arst_sat_stall_cnt", 64'(s_stall_cnt), 64'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h55; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      chk("arst_latency_valid", 64'(out_valid), 64'd1);
      chk("arst_latency_data", 64'(out_data), 64'h55);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
